// File: rtl/bsg_front_side_bus_hop_in_if.sv
// Bundle for the inbound front-side-bus hop: one upstream ready/valid stream
// plus two replicated consumer streams (bit/half 0 = local tile, 1 = next hop).
interface bsg_front_side_bus_hop_in_if #(
  parameter int width_p = 16
);
  logic                   v_i;
  logic [width_p-1:0]     data_i;
  logic                   ready_o;
  logic [1:0]             v_o;
  logic [2*width_p-1:0]   data_o;
  logic [1:0]             ready_i;

  modport master (
    output v_i, data_i, ready_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, data_i, ready_i,
    output ready_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_front_side_bus_hop_in.sv
// Inbound hop: small FIFO whose head word is replicated to two consumers and
// retired only once both have accepted it, in either order.
module bsg_front_side_bus_hop_in #(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input logic                          clk_i,
  input logic                          reset_i,
  bsg_front_side_bus_hop_in_if.slave   bus
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] head_r, tail_r;
  logic                empty_r, full_r;
  logic [1:0]          sent_r;

  logic                enq_s, deq_s;
  logic [1:0]          v_s, fire_s, done_s;
  logic [ptr_w_lp-1:0] head_inc_s, tail_inc_s;

  // Handshake decode; every term comes from registers or consumer/upstream inputs.
  always_comb begin
    enq_s      = 1'b0;
    v_s        = 2'b00;
    fire_s     = 2'b00;
    done_s     = 2'b00;
    deq_s      = 1'b0;
    head_inc_s = head_r + ptr_one_lp;
    tail_inc_s = tail_r + ptr_one_lp;
    enq_s      = bus.v_i & ~full_r;
    v_s        = {2{~empty_r}} & ~sent_r;
    fire_s     = v_s & bus.ready_i;
    done_s     = sent_r | fire_s;
    deq_s      = ~empty_r & done_s[0] & done_s[1];
  end

  assign bus.ready_o = ~full_r;
  assign bus.v_o     = v_s;
  assign bus.data_o  = {2{mem_r[head_r]}};

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[tail_r] <= bus.data_i;
    end
  end

  // Pointers, occupancy flags and per-consumer delivery tracking.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      sent_r  <= 2'b00;
    end else begin
      if (enq_s) begin
        tail_r <= tail_inc_s;
      end else begin
        tail_r <= tail_r;
      end

      // A retiring word clears both sent bits so the next head starts fresh.
      if (deq_s) begin
        head_r <= head_inc_s;
        sent_r <= 2'b00;
      end else begin
        head_r <= head_r;
        sent_r <= sent_r | fire_s;
      end

      // Flags carry the full/empty distinction that equal pointers cannot.
      if (enq_s && !deq_s) begin
        empty_r <= 1'b0;
        full_r  <= (tail_inc_s == head_r);
      end else if (deq_s && !enq_s) begin
        full_r  <= 1'b0;
        empty_r <= (head_inc_s == tail_r);
      end else begin
        empty_r <= empty_r;
        full_r  <= full_r;
      end
    end
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in.sv
// Directed bench for bsg_front_side_bus_hop_in with hand-computed expectations.
module tb_bsg_front_side_bus_hop_in;

  localparam int width_p = 16;
  localparam int els_p   = 2;

  logic clk_i;
  logic reset_i;
  int   total;
  int   bad;

  bsg_front_side_bus_hop_in_if #(.width_p(width_p)) bus_if ();

  bsg_front_side_bus_hop_in #(.width_p(width_p), .els_p(els_p)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus_if.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] v_exp,
                         input logic [15:0] d_exp, input logic rdy_exp);
    chk({tag, ".v_o"}, {62'd0, bus_if.v_o}, {62'd0, v_exp});
    if (v_exp != 2'b00) begin
      chk({tag, ".data_o"}, {32'd0, bus_if.data_o}, {32'd0, d_exp, d_exp});
    end else begin
      chk({tag, ".empty_v"}, {62'd0, bus_if.v_o}, 64'd0);
    end
    chk({tag, ".ready_o"}, {63'd0, bus_if.ready_o}, {63'd0, rdy_exp});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_i        = 1'b0;
    bus_if.v_i     = 1'b0;
    bus_if.data_i  = 16'h0000;
    bus_if.ready_i = 2'b00;

    // reset state
    step();
    chk_out("reset", 2'b00, 16'h0000, 1'b1);
    step();
    reset_i = 1'b1;

    // single word, both consumers ready
    bus_if.v_i     = 1'b1;
    bus_if.data_i  = 16'hA5A5;
    bus_if.ready_i = 2'b11;
    chk("single.ready_pre", {63'd0, bus_if.ready_o}, 64'd1);
    step();
    bus_if.v_i = 1'b0;
    chk_out("single.present", 2'b11, 16'hA5A5, 1'b1);
    step();
    chk_out("single.retired", 2'b00, 16'h0000, 1'b1);

    // back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      bus_if.v_i    = 1'b1;
      bus_if.data_i = 16'(i);
      step();
      chk_out($sformatf("stream%0d", i), 2'b11, 16'(i), 1'b1);
    end
    bus_if.v_i = 1'b0;
    step();
    chk_out("stream.drained", 2'b00, 16'h0000, 1'b1);

    // port 1 stalled, port 0 accepts first
    bus_if.ready_i = 2'b01;
    bus_if.v_i     = 1'b1;
    bus_if.data_i  = 16'h1111;
    step();
    chk_out("p0first.present", 2'b11, 16'h1111, 1'b1);
    bus_if.data_i = 16'h2222;
    step();
    chk_out("p0first.p0took", 2'b10, 16'h1111, 1'b0);
    bus_if.data_i = 16'h3333;
    step();
    chk_out("p0first.hold", 2'b10, 16'h1111, 1'b0);
    bus_if.ready_i = 2'b11;
    step();
    chk_out("p0first.retire", 2'b11, 16'h2222, 1'b1);
    step();
    chk_out("p0first.next", 2'b11, 16'h3333, 1'b1);
    bus_if.v_i = 1'b0;
    step();
    chk_out("p0first.drained", 2'b00, 16'h0000, 1'b1);

    // port 1 first, port 0 three cycles later
    bus_if.ready_i = 2'b10;
    bus_if.v_i     = 1'b1;
    bus_if.data_i  = 16'h4444;
    step();
    bus_if.v_i = 1'b0;
    chk_out("p1first.present", 2'b11, 16'h4444, 1'b1);
    step();
    bus_if.ready_i = 2'b00;
    chk_out("p1first.p1took", 2'b01, 16'h4444, 1'b1);
    step();
    chk_out("p1first.wait1", 2'b01, 16'h4444, 1'b1);
    step();
    chk_out("p1first.wait2", 2'b01, 16'h4444, 1'b1);
    bus_if.ready_i = 2'b11;
    step();
    chk_out("p1first.retire", 2'b00, 16'h0000, 1'b1);

    // fill, then stream through with wrap
    bus_if.ready_i = 2'b00;
    bus_if.v_i     = 1'b1;
    bus_if.data_i  = 16'h5000;
    step();
    bus_if.data_i = 16'h5001;
    step();
    chk_out("wrap.full", 2'b11, 16'h5000, 1'b0);
    bus_if.ready_i = 2'b11;
    bus_if.data_i  = 16'h5002;
    step();
    chk_out("wrap.first_deq", 2'b11, 16'h5001, 1'b1);
    for (int k = 2; k <= 11; k++) begin
      bus_if.data_i = 16'h5000 + 16'(k);
      step();
      chk_out($sformatf("wrap%0d", k), 2'b11, 16'h5000 + 16'(k), 1'b1);
    end
    bus_if.v_i = 1'b0;
    step();
    chk_out("wrap.drained", 2'b00, 16'h0000, 1'b1);

    // asynchronous reset with two words buffered and port 0 already served
    bus_if.ready_i = 2'b00;
    bus_if.v_i     = 1'b1;
    bus_if.data_i  = 16'h6001;
    step();
    bus_if.data_i = 16'h6002;
    step();
    bus_if.v_i     = 1'b0;
    bus_if.ready_i = 2'b01;
    step();
    bus_if.ready_i = 2'b00;
    chk_out("areset.before", 2'b10, 16'h6001, 1'b0);
    #2;
    reset_i = 1'b0;
    #1;
    chk_out("areset.during", 2'b00, 16'h0000, 1'b1);
    @(negedge clk_i);
    reset_i = 1'b1;
    step();
    chk_out("areset.after", 2'b00, 16'h0000, 1'b1);
    bus_if.ready_i = 2'b11;
    bus_if.v_i     = 1'b1;
    bus_if.data_i  = 16'hBEEF;
    step();
    bus_if.v_i = 1'b0;
    chk_out("areset.beef", 2'b11, 16'hBEEF, 1'b1);
    step();
    chk_out("areset.beef_done", 2'b00, 16'h0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
